// File: rtl/ysyx_23060208_rd_arbiter.sv
// Round-robin arbiter that merges the IFU and LSU read channels onto one
// AXI-lite read port. One transaction in flight; a watchdog answers SLVERR on a hung slave.
module ysyx_23060208_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [DATA_WIDTH-1:0] slv_araddr,
  output logic                  slv_arvalid,
  input  logic                  slv_arready,
  input  logic [DATA_WIDTH-1:0] slv_rdata,
  input  logic [1:0]            slv_rresp,
  input  logic                  slv_rvalid,
  output logic                  slv_rready
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DRAIN} state_e;

  localparam logic             M_IFU    = 1'b0;
  localparam logic             M_LSU    = 1'b1;
  localparam logic [1:0]       RESP_ERR = 2'b10;
  // Last DATA cycle that may still wait; the next silent cycle would exceed TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Masters gathered into arrays indexed by owner (0 = IFU, 1 = LSU).
  logic [1:0][DATA_WIDTH-1:0] m_araddr;
  logic [1:0]                 m_arvalid;
  logic [1:0]                 m_rready;
  logic [1:0]                 m_arready;
  logic [1:0]                 m_rvalid;
  logic [1:0][DATA_WIDTH-1:0] m_rdata;
  logic [1:0][1:0]            m_rresp;

  assign m_araddr  = {lsu_araddr, ifu_araddr};
  assign m_arvalid = {lsu_arvalid, ifu_arvalid};
  assign m_rready  = {lsu_rready, ifu_rready};

  assign ifu_arready = m_arready[M_IFU];
  assign ifu_rvalid  = m_rvalid[M_IFU];
  assign ifu_rdata   = m_rdata[M_IFU];
  assign ifu_rresp   = m_rresp[M_IFU];
  assign lsu_arready = m_arready[M_LSU];
  assign lsu_rvalid  = m_rvalid[M_LSU];
  assign lsu_rdata   = m_rdata[M_LSU];
  assign lsu_rresp   = m_rresp[M_LSU];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|m_arvalid) begin
          // On a tie, the master that did not win last time gets the bus.
          owner_d = (&m_arvalid) ? ~last_q : m_arvalid[M_LSU];
          last_d  = owner_d;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_arvalid[owner_q] && slv_arready) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (slv_rvalid) begin
          if (m_rready[owner_q]) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ERR;
        end
      end
      ERR: begin
        if (m_rready[owner_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (slv_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_arready   = '0;
    m_rvalid    = '0;
    m_rdata     = '0;
    m_rresp     = '0;
    slv_araddr  = '0;
    slv_arvalid = 1'b0;
    slv_rready  = 1'b0;
    case (state_q)
      ADDR: begin
        slv_araddr         = m_araddr[owner_q];
        slv_arvalid        = m_arvalid[owner_q];
        m_arready[owner_q] = slv_arready;
      end
      DATA: begin
        m_rvalid[owner_q] = slv_rvalid;
        m_rdata[owner_q]  = slv_rdata;
        m_rresp[owner_q]  = slv_rresp;
        slv_rready        = m_rready[owner_q];
      end
      ERR: begin
        m_rvalid[owner_q] = 1'b1;
        m_rresp[owner_q]  = RESP_ERR;
      end
      // A late beat from the hung slave is swallowed here, never forwarded.
      DRAIN: slv_rready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M_IFU;
      last_q  <= M_LSU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Scoreboard bench for the IFU/LSU read arbiter: a behavioural slave and two
// masters; expected beats are queued at AR acceptance and checked on R handshake.
module tb_ysyx_23060208_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr, slv_araddr;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] ifu_rdata, lsu_rdata, slv_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, slv_rresp;
  logic        slv_arvalid, slv_arready, slv_rvalid, slv_rready;

  always #5 clk = ~clk;

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .slv_araddr(slv_araddr), .slv_arvalid(slv_arvalid), .slv_arready(slv_arready),
    .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  int   checks = 0;
  int   errors = 0;

  // Slave model knobs and state.
  logic        sl_hang, sl_ovr_en;
  logic [31:0] sl_ovr;
  logic [1:0]  sl_resp;
  int          sl_dly;
  logic        p_pend;
  logic [31:0] p_addr;
  int          p_dly;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // One clock: observe handshakes before the edge, then update masters and slave after it.
  task automatic tick();
    exp_t e;
    logic ifu_hs, lsu_hs;
    #1;
    ifu_hs = ifu_arvalid && ifu_arready;
    lsu_hs = lsu_arvalid && lsu_arready;
    if (ifu_rvalid && ifu_rready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL ifu_unexpected_beat data=%h resp=%b", ifu_rdata, ifu_rresp);
      end else begin
        e = sb.pop_front();
        if ({1'b0, ifu_rdata, ifu_rresp} !== {e.id, e.data, e.resp}) begin
          errors++;
          $display("FAIL ifu_beat got id=0 data=%h resp=%b want id=%0d data=%h resp=%b",
                   ifu_rdata, ifu_rresp, e.id, e.data, e.resp);
        end
      end
    end
    if (lsu_rvalid && lsu_rready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL lsu_unexpected_beat data=%h resp=%b", lsu_rdata, lsu_rresp);
      end else begin
        e = sb.pop_front();
        if ({1'b1, lsu_rdata, lsu_rresp} !== {e.id, e.data, e.resp}) begin
          errors++;
          $display("FAIL lsu_beat got id=1 data=%h resp=%b want id=%0d data=%h resp=%b",
                   lsu_rdata, lsu_rresp, e.id, e.data, e.resp);
        end
      end
    end
    if (ifu_hs) begin
      checks++;
      if (slv_araddr !== ifu_araddr || slv_arvalid !== 1'b1 || lsu_hs) begin
        errors++; $display("FAIL ifu_ar_route got addr=%h vld=%b want addr=%h vld=1",
                           slv_araddr, slv_arvalid, ifu_araddr);
      end
      e.id = 1'b0; e.data = sl_hang ? 32'h0 : (sl_ovr_en ? sl_ovr : mem_f(ifu_araddr));
      e.resp = sl_hang ? 2'b10 : sl_resp;
      sb.push_back(e); grant_log.push_back(1'b0);
    end
    if (lsu_hs) begin
      checks++;
      if (slv_araddr !== lsu_araddr || slv_arvalid !== 1'b1) begin
        errors++; $display("FAIL lsu_ar_route got addr=%h vld=%b want addr=%h vld=1",
                           slv_araddr, slv_arvalid, lsu_araddr);
      end
      e.id = 1'b1; e.data = sl_hang ? 32'h0 : (sl_ovr_en ? sl_ovr : mem_f(lsu_araddr));
      e.resp = sl_hang ? 2'b10 : sl_resp;
      sb.push_back(e); grant_log.push_back(1'b1);
    end
    if (slv_arvalid && slv_arready) begin
      p_pend = 1'b1; p_addr = slv_araddr; p_dly = sl_dly;
    end else if (slv_rvalid && slv_rready) begin
      p_pend = 1'b0;
    end else if (p_pend && p_dly > 0) begin
      p_dly--;
    end
    @(posedge clk); #1;
    if (ifu_hs) ifu_arvalid = 1'b0;
    if (lsu_hs) lsu_arvalid = 1'b0;
    slv_arready = 1'b1;
    slv_rvalid  = p_pend && (p_dly == 0) && !sl_hang;
    slv_rdata   = slv_rvalid ? (sl_ovr_en ? sl_ovr : mem_f(p_addr)) : 32'h0;
    slv_rresp   = slv_rvalid ? sl_resp : 2'b00;
    #1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while ((ifu_arvalid || lsu_arvalid || sb.size() != 0) && n < budget) begin
      tick(); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL wait_done timeout pending=%0d want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    sl_hang = 1'b0; sl_ovr_en = 1'b0; sl_ovr = 32'h0; sl_resp = 2'b00; sl_dly = 0;
    p_pend = 1'b0; p_dly = 0; p_addr = 32'h0;
    sb.delete(); grant_log.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid, lsu_rdata,
         lsu_rresp, slv_araddr, slv_arvalid, slv_rready} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero want all 0");
    end
    tick();
    checks++;
    if ({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, slv_arvalid, slv_rready} !== '0) begin
      errors++; $display("FAIL idle_outputs got nonzero want all 0");
    end
  endtask

  task automatic test_ifu_single();
    int n;
    do_reset();
    sl_ovr_en = 1'b1; sl_ovr = 32'h0000_0413;
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    wait_done(20, n);
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL ifu_single_latency got %0d want 3", n);
    end
    checks++;
    if ({ifu_rvalid, lsu_rvalid, slv_arvalid, slv_rready, ifu_arready} !== 5'b0) begin
      errors++; $display("FAIL ifu_single_idle got %b want 00000",
                         {ifu_rvalid, lsu_rvalid, slv_arvalid, slv_rready, ifu_arready});
    end
    sl_ovr_en = 1'b0;
  endtask

  task automatic test_arbitration();
    int n;
    do_reset();
    ifu_araddr = 32'h8000_0100; lsu_araddr = 32'h8000_2000;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    wait_done(40, n);
    ifu_araddr = 32'h8000_0104; lsu_araddr = 32'h8000_2004;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    wait_done(40, n);
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("FAIL arb_grant_count got %0d want 4", grant_log.size());
    end else if ({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== 4'b0101) begin
      errors++; $display("FAIL arb_order got %b want 0101",
                         {grant_log[0], grant_log[1], grant_log[2], grant_log[3]});
    end
  endtask

  task automatic test_backpressure();
    int n;
    sl_ovr_en = 1'b1; sl_ovr = 32'hDEAD_BEEF;
    lsu_rready = 1'b0; lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
    n = 0;
    while (lsu_arvalid && n < 20) begin tick(); n++; end
    ifu_araddr = 32'h8000_0200; ifu_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({slv_rvalid, slv_rready, lsu_rvalid, ifu_arready, ifu_rvalid} !== 5'b10100 ||
          lsu_rdata !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL hold_cycle%0d got rv/rr/lrv/iar/irv=%b data=%h want 10100 deadbeef",
                           i, {slv_rvalid, slv_rready, lsu_rvalid, ifu_arready, ifu_rvalid}, lsu_rdata);
      end
      tick();
    end
    lsu_rready = 1'b1;
    wait_done(40, n);
    sl_ovr_en = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    sl_hang = 1'b1; ifu_rready = 1'b0;
    ifu_araddr = 32'h8000_0300; ifu_arvalid = 1'b1;
    n = 0;
    while (ifu_arvalid && n < 20) begin tick(); n++; end
    n = 0;
    while (!ifu_rvalid && n < 20) begin tick(); n++; end
    checks++;
    if (n != 4 || ifu_rresp !== 2'b10 || ifu_rdata !== 32'h0 || slv_rready !== 1'b0) begin
      errors++; $display("FAIL timeout_err got cycles=%0d resp=%b data=%h srr=%b want 4 10 0 0",
                         n, ifu_rresp, ifu_rdata, slv_rready);
    end
    ifu_rready = 1'b1;
    tick();
    checks++;
    if ({slv_rready, ifu_rvalid, lsu_rvalid} !== 3'b100 || sb.size() != 0) begin
      errors++; $display("FAIL drain_state got srr/irv/lrv=%b pending=%0d want 100 0",
                         {slv_rready, ifu_rvalid, lsu_rvalid}, sb.size());
    end
    sl_hang = 1'b0;
    tick();
    checks++;
    if ({slv_rvalid, slv_rready, ifu_rvalid, lsu_rvalid} !== 4'b1100) begin
      errors++; $display("FAIL drain_absorb got %b want 1100",
                         {slv_rvalid, slv_rready, ifu_rvalid, lsu_rvalid});
    end
    tick();
    ifu_araddr = 32'h8000_0400; ifu_arvalid = 1'b1;
    wait_done(20, n);
  endtask

  task automatic test_reset_mid();
    int n;
    sl_dly = 5; lsu_araddr = 32'h8000_0500; lsu_arvalid = 1'b1;
    n = 0;
    while (lsu_arvalid && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1; p_pend = 1'b0; sb.delete();
    ifu_araddr = 32'h8000_0600; lsu_araddr = 32'h8000_0700;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    tick();
    checks++;
    if ({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid, lsu_rdata,
         lsu_rresp, slv_araddr, slv_arvalid, slv_rready} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got nonzero want all 0");
    end
    rst = 1'b0; sl_dly = 0; grant_log.delete();
    wait_done(40, n);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_order got size=%0d first=%b want 2 0",
                         grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 1'bx);
    end
  endtask

  task automatic test_slverr();
    int n;
    grant_log.delete();
    sl_resp = 2'b10; lsu_araddr = 32'h8000_0800; lsu_arvalid = 1'b1;
    wait_done(20, n);
    sl_resp = 2'b00;
    ifu_araddr = 32'h8000_0900; lsu_araddr = 32'h8000_0A00;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    wait_done(40, n);
    checks++;
    if (grant_log.size() != 3) begin
      errors++; $display("FAIL slverr_grant_count got %0d want 3", grant_log.size());
    end else if ({grant_log[0], grant_log[1], grant_log[2]} !== 3'b101) begin
      errors++; $display("FAIL slverr_order got %b want 101",
                         {grant_log[0], grant_log[1], grant_log[2]});
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; lsu_araddr = '0; ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    slv_arready = 1'b1; slv_rvalid = 1'b0; slv_rdata = '0; slv_rresp = '0;
    test_reset();
    test_ifu_single();
    test_arbitration();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_slverr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
